dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 137 +++++++++++++
 tb/tb_dmem_lsu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Single-port data memory with an RV32 load/store front end: byte/half/word
// access, sign/zero extension, fault detection and a one-deep response register.
module dmem_lsu #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    // state | meaning
    // IDLE  | no response pending
    // RESP  | response held on rsp_* until consumed
    typedef enum logic {IDLE, RESP} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t      state_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // Contents start at zero from the configuration image; reset never touches them.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  f3_ok;
    logic                  misalign;
    logic                  acc_err;
    logic                  accept;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;
    logic [31:0]           rsp_rdata_d;

    assign off      = req_addr_i - BASE_ADDR;
    // Range check on the offset rather than BASE_ADDR + 4*DEPTH avoids 32-bit wrap.
    assign in_range = (req_addr_i >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign idx      = off[DEPTH_LOG2+1:2];

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we_i;
            default:                f3_ok = 1'b0;
        endcase
    end

    assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign acc_err  = !f3_ok || misalign || !in_range;

    assign req_ready_o = !rst && ((state_q == IDLE) || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                be        = 4'b0001 << req_addr_i[1:0];
                wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be        = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word  = mem_q[idx];
    assign rd_shift = rd_word >> {req_addr_i[1:0], 3'b000};
    assign rd_half  = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (req_funct3_i)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    assign rsp_rdata_d = (req_we_i || acc_err) ? 32'd0 : load_data;

    always_ff @(posedge clk) begin
        if (accept && req_we_i && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= acc_err;
        end else if ((state_q == RESP) && rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu: stores/loads, extension, faults,
// backpressure, back-to-back issue and mid-operation reset.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    dmem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance,
    // so consecutive calls issue on consecutive cycles.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err);
        set_req(we, f3, addr, wd);
        rsp_ready = 1'b1;
        #1 check({tag, "/rdy"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check({tag, "/vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "/data"}, rsp_rdata, exp_data);
        check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/rdy", 32'(req_ready), 32'd0);
        check("reset/vld", 32'(rsp_valid), 32'd0);
        check("reset/data", rsp_rdata, 32'd0);
        check("reset/err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset/rdy", 32'(req_ready), 32'd1);

        txn("sw_beef", 1'b1, F_W, 32'h1000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn("lw_beef", 1'b0, F_W, 32'h1000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        txn("sb_55",   1'b1, F_B, 32'h1000_0011, 32'h0000_0055, 32'd0, 1'b0);
        txn("lw_55",   1'b0, F_W, 32'h1000_0010, 32'd0, 32'hDEAD_55EF, 1'b0);
        txn("lb_de",   1'b0, F_B, 32'h1000_0013, 32'd0, 32'hFFFF_FFDE, 1'b0);
        txn("lbu_de",  1'b0, F_BU, 32'h1000_0013, 32'd0, 32'h0000_00DE, 1'b0);
        txn("lh_dead", 1'b0, F_H, 32'h1000_0012, 32'd0, 32'hFFFF_DEAD, 1'b0);
        txn("lhu_55ef", 1'b0, F_HU, 32'h1000_0010, 32'd0, 32'h0000_55EF, 1'b0);
        txn("sh_hi",   1'b1, F_H, 32'h1000_0016, 32'hABCD_8001, 32'd0, 1'b0);
        txn("lw_sh",   1'b0, F_W, 32'h1000_0014, 32'd0, 32'h8001_0000, 1'b0);

        txn("lw_mis",  1'b0, F_W, 32'h1000_0012, 32'd0, 32'd0, 1'b1);
        txn("sh_mis",  1'b1, F_H, 32'h1000_0011, 32'h0000_1234, 32'd0, 1'b1);
        txn("rb_sh",   1'b0, F_W, 32'h1000_0010, 32'd0, 32'hDEAD_55EF, 1'b0);
        txn("lw_top",  1'b0, F_W, 32'h1000_4000, 32'd0, 32'd0, 1'b1);
        txn("sw_top",  1'b1, F_W, 32'h1000_4000, 32'h1111_1111, 32'd0, 1'b1);
        txn("rb_alias", 1'b0, F_W, 32'h1000_0000, 32'd0, 32'd0, 1'b0);
        txn("sw_last", 1'b1, F_W, 32'h1000_3FFC, 32'hCAFE_F00D, 32'd0, 1'b0);
        txn("lw_last", 1'b0, F_W, 32'h1000_3FFC, 32'd0, 32'hCAFE_F00D, 1'b0);
        txn("lw_low",  1'b0, F_W, 32'h0FFF_FFFC, 32'd0, 32'd0, 1'b1);
        txn("ld_f011", 1'b0, 3'b011, 32'h1000_0010, 32'd0, 32'd0, 1'b1);
        txn("st_f100", 1'b1, 3'b100, 32'h1000_0010, 32'hFFFF_FFFF, 32'd0, 1'b1);
        txn("rb_f3",   1'b0, F_W, 32'h1000_0010, 32'd0, 32'hDEAD_55EF, 1'b0);

        // Backpressure: response held, new request stalled, then both on one edge.
        set_req(1'b0, F_W, 32'h1000_0010, 32'd0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 set_req(1'b0, F_W, 32'h1000_3FFC, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp/rdy", 32'(req_ready), 32'd0);
            check("bp/vld", 32'(rsp_valid), 32'd1);
            check("bp/data", rsp_rdata, 32'hDEAD_55EF);
            check("bp/err", 32'(rsp_err), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 check("bp/rdy_release", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp/next_vld", 32'(rsp_valid), 32'd1);
        check("bp/next_data", rsp_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        check("bp/drained", 32'(rsp_valid), 32'd0);

        // Back-to-back loads, one per cycle.
        b2b_addr[0] = 32'h1000_0010; b2b_exp[0] = 32'hDEAD_55EF;
        b2b_addr[1] = 32'h1000_3FFC; b2b_exp[1] = 32'hCAFE_F00D;
        b2b_addr[2] = 32'h1000_0014; b2b_exp[2] = 32'h8001_0000;
        b2b_addr[3] = 32'h1000_0000; b2b_exp[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("b2b/vld", 32'(rsp_valid), 32'd1);
                check("b2b/data", rsp_rdata, b2b_exp[i-1]);
            end
            set_req(1'b0, F_W, b2b_addr[i], 32'd0);
            #1 check("b2b/rdy", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b/vld_last", 32'(rsp_valid), 32'd1);
        check("b2b/data_last", rsp_rdata, b2b_exp[3]);
        @(negedge clk);
        check("b2b/drained", 32'(rsp_valid), 32'd0);

        // Reset with a response pending.
        set_req(1'b0, F_W, 32'h1000_0010, 32'd0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 begin req_valid = 1'b0; rst = 1'b1; end
        @(negedge clk);
        check("rst/rdy_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst/vld", 32'(rsp_valid), 32'd0);
        check("rst/data", rsp_rdata, 32'd0);
        check("rst/rdy_after", 32'(req_ready), 32'd1);
        txn("rst/keep", 1'b0, F_W, 32'h1000_0010, 32'd0, 32'hDEAD_55EF, 1'b0);
        txn("rst/keep2", 1'b0, F_W, 32'h1000_3FFC, 32'd0, 32'hCAFE_F00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
